// File: rtl/datapath_pkg.sv
// Datapath constants shared by the register file, forwarding unit
// and writeback arbiter; also the registered writeback bundle type.
package datapath_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] wa;
    logic [REG_DATA_W-1:0] wd;
  } wb_t;

  function automatic logic [NUM_REGS-1:0] addr_onehot(
    input logic                  we,
    input logic [REG_ADDR_W-1:0] wa
  );
    return we ? (NUM_REGS'(1) << wa) : '0;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Single-winner grant selector: round-robin from ptr+1 when
// WB_ARB_ROUND_ROBIN_EN is defined, else lowest index wins.
module rr_arbiter #(
  parameter  int NREQ = 3,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  input  logic            enable,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic w_found;
  int   w_j;

  // Walk from ptr+1 around the ring; first valid requester wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    w_j     = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_j = (int'(ptr) + k) % NREQ;
      if (enable && !w_found && req[w_j]) begin
        w_found  = 1'b1;
        gnt[w_j] = 1'b1;
        gnt_idx  = IW'(w_j);
      end
    end
  end
`else
  logic w_unused_ptr;
  assign w_unused_ptr = ^ptr;

  // Scan high to low so the lowest valid index overrides.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (enable && req[i]) begin
        gnt     = '0;
        gnt[i]  = 1'b1;
        gnt_idx = IW'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write port arbiter: NREQ writeback sources, one write
// per cycle, registered port. WB_ARB_ROUND_ROBIN_EN selects round-robin.
module regfile_wb_arbiter
  import datapath_pkg::*;
#(
  parameter  int NREQ  = 3,
  parameter  int CNT_W = 16,
  localparam int IW    = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       hold,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*REG_ADDR_W-1:0] req_wa,
  input  logic [NREQ*REG_DATA_W-1:0] req_wd,
  output logic                       wb_we,
  output logic [REG_ADDR_W-1:0]      wb_wa,
  output logic [REG_DATA_W-1:0]      wb_wd,
  output logic [IW-1:0]              wb_src,
  output logic [NUM_REGS-1:0]        pend_mask,
  output logic [CNT_W-1:0]           contention_cnt
);

  logic [NREQ-1:0]       w_gnt;
  logic [IW-1:0]         w_idx;
  logic [IW-1:0]         w_ptr;
  logic                  w_enable;
  logic                  w_accept;
  logic                  w_contend;
  logic [REG_ADDR_W-1:0] w_wa;
  logic [REG_DATA_W-1:0] w_wd;

  wb_t                   r_wb;
  logic [IW-1:0]         r_src;
  logic [CNT_W-1:0]      r_cnt;

  assign w_enable = ~hold & ~reset;

`ifdef WB_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] r_ptr;

  // Pointer tracks the last winner; reset value lets index 0 win first.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= IW'(NREQ - 1);
    end else if (w_accept) begin
      r_ptr <= w_idx;
    end
  end

  assign w_ptr = r_ptr;
`else
  assign w_ptr = '0;
`endif

  rr_arbiter #(
    .NREQ    (NREQ)
  ) u_arb (
    .req     (req_valid),
    .ptr     (w_ptr),
    .enable  (w_enable),
    .gnt     (w_gnt),
    .gnt_idx (w_idx)
  );

  assign req_ready = w_gnt;
  assign w_accept  = |w_gnt;
  assign w_wa      = req_wa[int'(w_idx)*REG_ADDR_W +: REG_ADDR_W];
  assign w_wd      = req_wd[int'(w_idx)*REG_DATA_W +: REG_DATA_W];
  assign w_contend = ~hold & ($countones(req_valid) >= 2);

  // Latch the winner onto the write port; x0 writes retire silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb  <= '0;
      r_src <= '0;
    end else begin
      r_wb.we <= w_accept && (w_wa != ZERO_REG);
      if (w_accept) begin
        r_wb.wa <= w_wa;
        r_wb.wd <= w_wd;
        r_src   <= w_idx;
      end
    end
  end

  // Saturating count of cycles where some valid requester lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (w_contend && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign wb_we          = r_wb.we;
  assign wb_wa          = r_wb.wa;
  assign wb_wd          = r_wb.wd;
  assign wb_src         = r_src;
  assign pend_mask      = addr_onehot(r_wb.we, r_wb.wa);
  assign contention_cnt = r_cnt;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between NREQ writeback sources (e.g. ALU, load unit, multi-cycle mul/div).
- Per-source valid/ready handshake; one winner per cycle; the winner is registered onto the write port (we/wa/wd) one cycle after acceptance.
- Also exports a pending-write mask for the forwarding unit and a saturating contention counter for performance monitoring.

Parameters:
- NREQ, 3, number of writeback requesters (2..8)
- CNT_W, 16, width of the contention counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- hold  in  1  freeze arbitration; no grants while high
- req_valid  in  NREQ  requester i has a write pending
- req_ready  out  NREQ  combinational grant; handshake when valid & ready
- req_wa  in  NREQ*5  flattened destination addresses; slice i = [5i+4:5i]
- req_wd  in  NREQ*32  flattened write data; slice i = [32i+31:32i]
- wb_we  out  1  registered write enable to the register file
- wb_wa  out  5  registered write address
- wb_wd  out  32  registered write data
- wb_src  out  $clog2(NREQ)  index of the requester that produced the current wb_* write
- pend_mask  out  32  one-hot of wb_wa when wb_we=1, else 0
- contention_cnt  out  CNT_W  cycles in which a valid requester lost arbitration

Behaviour:
- Reset values: wb_we=0, wb_wa=0, wb_wd=0, wb_src=0, pend_mask=0, contention_cnt=0, round-robin pointer=NREQ-1 (so index 0 wins first).
- req_ready is combinational from req_valid, hold and the pointer. At most one bit is set, and only for a valid requester. All bits are 0 while hold=1 or reset=1.
- Acceptance: req_valid[i] & req_ready[i] at edge N.
  - At edge N: wb_we=1, wb_wa=req_wa[i], wb_wd=req_wd[i], wb_src=i.
  - These values are visible for cycle N+1 only; latency is 1 cycle.
- No acceptance in a cycle (including hold=1): wb_we=0 next cycle. wb_wa, wb_wd and wb_src keep their previous values.
- Writes to address 0: the request is still granted and retired (handshake completes). wb_we stays 0 and pend_mask stays 0. wb_wa=0 and wb_src are still updated.
- The write port never back-pressures, so no output buffering is needed. Throughput is one write per cycle.
- Requesters must hold valid, wa and wd stable until ready; the arbiter does not check this.
- contention_cnt increments by 1 in any cycle where hold=0 and popcount(req_valid) >= 2. It saturates at all-ones and clears only on reset.
- hold=1 with valid requesters does not count as contention.
- pend_mask = wb_we ? (32'b1 << wb_wa) : 0. Derived from registered outputs; no extra state.
- Reset asserted mid-operation: an in-flight registered write is discarded (wb_we=0 next cycle). A requester holding valid is re-arbitrated after reset deasserts.

Optional Feature:
- Macro WB_ARB_ROUND_ROBIN_EN.
- Defined: round-robin.
  - Search starts at pointer+1 (mod NREQ); first valid index wins.
  - Pointer loads the winning index on every acceptance; it is unchanged when no acceptance occurs.
- Undefined: fixed priority, lowest index wins. The pointer register is not instantiated.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package (datapath_pkg): REG_ADDR_W=5, REG_DATA_W=32, NUM_REGS=32, ZERO_REG=5'd0. These are shared with the register file and forwarding unit.
- One sub-module: rr_arbiter.
  - Parameterised NREQ; inputs req, ptr, enable; outputs one-hot gnt and gnt_idx.
  - Contains both selection modes under the macro.
  - The top level holds the output registers, the pointer and the counter.

Test Plan:
- Reset, then req_valid=3'b001, wa=5, wd=0xDEADBEEF -> req_ready=3'b001 same cycle; next cycle wb_we=1, wa=5, wd=0xDEADBEEF, wb_src=0, pend_mask=0x00000020.
- req_valid=3'b111 held for 3 accepts:
  - RR build: grants 0, 1, 2 in order.
  - Fixed build: grants 0 three times.
  - Both builds: contention_cnt=3.
- Requester 1 writes wa=0, wd=0x1234 -> handshake completes; next cycle wb_we=0, pend_mask=0.
- hold=1 for 4 cycles with req_valid=3'b110 -> req_ready=0 and wb_we=0 throughout; contention_cnt unchanged. Release hold -> RR build grants index 1 first.
- CNT_W=4, contention for 20 cycles -> contention_cnt saturates at 15.
- Accept at edge N, reset asserted during cycle N+1 -> wb_we=0 after the reset edge and all outputs at reset values. After reset deasserts, the still-valid requester is granted and its write appears one cycle later.
